// File: rtl/electrode_pkg.sv
// electrode_pkg: shared state encoding and sprite geometry for the electrode hazard
package electrode_pkg;
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ARM = 2'b01;
  localparam logic [1:0] ST_ACTIVE = 2'b10;
  localparam logic [1:0] ST_COOL = 2'b11;
  localparam int XCEN = 40;
  localparam int YCEN = 20;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ARM = ST_ARM,
    ACTIVE = ST_ACTIVE,
    COOL = ST_COOL
  } state_t;
endpackage

// File: rtl/electrode_ctrl_phase_timer.sv
// phase_timer: up-counter that wraps at a compare value and pulses tc on that cycle
module phase_timer #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] cmp,
  output logic          tc
);
  logic [CW-1:0] count;
  assign tc = en & (count == cmp);
  // count while enabled, wrapping to zero on the terminal cycle
  always_ff @(posedge clk)
    if (reset || clr) count <= '0;
    else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/electrode_ctrl.sv
// electrode_ctrl: sequences the electrode hazard through idle, blinking arm, zap and cooldown
module electrode_ctrl
  import electrode_pkg::*;
#(
  parameter int BLINK_HALF = 3125000,
  parameter int ARM_BLINKS = 4,
  parameter int ACTIVE_CYCLES = 6250000,
  parameter int COOLDOWN_CYCLES = 3125000,
  parameter int CW = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       trigger,
  input  logic       abort,
  output logic [1:0] state,
  output logic       blink_clk,
  output logic       zap,
  output logic       fired,
  output logic       ready
);
  localparam int HW = (2 * ARM_BLINKS) > 1 ? $clog2(2 * ARM_BLINKS) : 1;
  state_t st, nxt;
  logic [HW-1:0] hcnt;
  logic [CW-1:0] cmp;
  logic tc, last_half;
  assign state = st;
  assign last_half = hcnt == HW'(2 * ARM_BLINKS - 1);
  assign cmp = st == ARM ? CW'(BLINK_HALF - 1) : st == ACTIVE ? CW'(ACTIVE_CYCLES - 1) : CW'(COOLDOWN_CYCLES - 1);
  // the timer restarts from zero on every state change so each state gets its full length
  phase_timer #(.CW(CW)) u_timer (
    .clk(clk),
    .reset(reset),
    .clr(nxt != st),
    .en(st != IDLE),
    .cmp(cmp),
    .tc(tc)
  );
  // next state: enable low beats abort, abort beats expiry, expiry beats trigger
  always_comb begin
    nxt = st;
    if (!enable) nxt = IDLE;
    else
      case (st)
        IDLE:    nxt = trigger ? ARM : IDLE;
        ARM:     nxt = abort ? IDLE : (tc && last_half) ? ACTIVE : ARM;
        ACTIVE:  nxt = (abort || tc) ? COOL : ACTIVE;
        default: nxt = tc ? IDLE : COOL;
      endcase
  end
  // outputs are registered alongside the state; blink starts high on ARM entry
  always_ff @(posedge clk)
    if (reset) begin
      st <= IDLE;
      blink_clk <= 1'b0;
      zap <= 1'b0;
      fired <= 1'b0;
      ready <= 1'b1;
      hcnt <= '0;
    end else begin
      st <= nxt;
      blink_clk <= (nxt == ARM) & ((st != ARM) | (blink_clk ^ tc));
      zap <= nxt == ACTIVE;
      fired <= (nxt == ACTIVE) & (st != ACTIVE);
      ready <= nxt == IDLE;
      hcnt <= (nxt == ARM && st == ARM) ? hcnt + HW'(tc) : '0;
    end
endmodule

// File: tb/tb_electrode_ctrl.sv
// tb_electrode_ctrl: directed and randomized checks of electrode_ctrl against an age-based model
module tb_electrode_ctrl;
  localparam int BH = 4, AB = 2, AC = 5, CC = 3;
  logic clk = 0, reset = 1, enable = 1, trigger = 0, abort = 0;
  logic [1:0] state;
  logic blink_clk, zap, fired, ready;
  int tests = 0, fails = 0;
  int m_st = 0, m_age = 0;

  electrode_ctrl #(.BLINK_HALF(BH), .ARM_BLINKS(AB), .ACTIVE_CYCLES(AC), .COOLDOWN_CYCLES(CC), .CW(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger), .abort(abort),
    .state(state), .blink_clk(blink_clk), .zap(zap), .fired(fired), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // model: which phase we are in and how many cycles we have spent there
  always @(posedge clk)
    if (reset || !enable) begin
      m_st <= 0;
      m_age <= 0;
    end else
      case (m_st)
        0: if (trigger) begin m_st <= 1; m_age <= 0; end
        1: if (abort) begin m_st <= 0; m_age <= 0; end
           else if (m_age + 1 == 2 * AB * BH) begin m_st <= 2; m_age <= 0; end
           else m_age <= m_age + 1;
        2: if (abort || m_age + 1 == AC) begin m_st <= 3; m_age <= 0; end
           else m_age <= m_age + 1;
        default: if (m_age + 1 == CC) begin m_st <= 0; m_age <= 0; end
           else m_age <= m_age + 1;
      endcase

  // every cycle: outputs must match what the model's phase and age imply
  always @(negedge clk) begin
    check("m_state", state, m_st);
    check("m_blink", blink_clk, m_st == 1 && ((m_age / BH) % 2 == 0));
    check("m_zap", zap, m_st == 2);
    check("m_fired", fired, m_st == 2 && m_age == 0);
    check("m_ready", ready, m_st == 0);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_ready", ready, 1);
    check("rst_blink", blink_clk, 0);
    reset = 0;
    @(negedge clk);
    trigger = 1;
    @(negedge clk);
    trigger = 0;
    check("s1_c1_state", state, 1);
    check("s1_c1_blink", blink_clk, 1);
    repeat (4) @(negedge clk);
    check("s1_c5_blink", blink_clk, 0);
    repeat (4) @(negedge clk);
    check("s1_c9_blink", blink_clk, 1);
    repeat (7) @(negedge clk);
    check("s1_c16_state", state, 1);
    @(negedge clk);
    check("s1_c17_state", state, 2);
    check("s1_c17_fired", fired, 1);
    check("s1_c17_zap", zap, 1);
    @(negedge clk);
    check("s1_c18_fired", fired, 0);
    repeat (4) @(negedge clk);
    check("s1_c22_state", state, 3);
    check("s1_c22_zap", zap, 0);
    repeat (3) @(negedge clk);
    check("s1_c25_state", state, 0);
    check("s1_c25_ready", ready, 1);
    trigger = 1;
    @(negedge clk);
    trigger = 0;
    repeat (5) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("s2_c7_state", state, 0);
    check("s2_c7_blink", blink_clk, 0);
    trigger = 1;
    @(negedge clk);
    trigger = 0;
    check("s2_rearm_state", state, 1);
    check("s2_rearm_blink", blink_clk, 1);
    repeat (17) @(negedge clk);
    check("s3_active", state, 2);
    abort = 1;
    @(negedge clk);
    abort = 0;
    check("s3_abort_state", state, 3);
    check("s3_abort_zap", zap, 0);
    repeat (3) @(negedge clk);
    check("s3_idle", state, 0);
    enable = 0;
    trigger = 1;
    repeat (4) @(negedge clk);
    check("s4_disabled", state, 0);
    enable = 1;
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    trigger = 0;
    check("s6_rst_state", state, 0);
    check("s6_rst_blink", blink_clk, 0);
    check("s6_rst_ready", ready, 1);
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      enable = $urandom_range(0, 59) != 0;
      trigger = $urandom_range(0, 3) == 0;
      abort = $urandom_range(0, 29) == 0;
      @(negedge clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
